// File: rtl/axi_dma_pkg.sv
// Shared encodings and helpers for the AXI write DMA: transfer sizes, response codes,
// burst type, the 4 KB page constant and the top-level FSM state type.
package axi_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] SIZE_1B  = 3'b000;
  localparam logic [2:0] SIZE_2B  = 3'b001;
  localparam logic [2:0] SIZE_4B  = 3'b010;
  localparam logic [2:0] SIZE_8B  = 3'b011;
  localparam logic [2:0] SIZE_16B = 3'b100;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam int BOUNDARY_4K = 4096;

  // log2 of a power-of-two byte count (bytes per data beat)
  function automatic int bytes_log2(input int bytes);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == bytes) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_dma_wr_len_fifo.sv
// Small show-ahead FIFO holding AWLEN values of bursts whose address has been accepted
// but whose data beats have not all been sent yet.
module axi_dma_wr_len_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < 2**AW; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop_ok) r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_dma_wr_mo.sv
// AXI4 write DMA with decoupled AW/W/B channels: bursts are split at 4 KB pages and
// up to MAX_OUTSTANDING bursts may be awaiting their write response.
module axi_dma_wr_mo
  import axi_dma_pkg::*;
#(
  parameter int AXI_WIDTH_AD    = 32,
  parameter int AXI_WIDTH_DA    = 32,
  parameter int AXI_WIDTH_ID    = 4,
  parameter int OUT_BITS_TRANS  = 18,
  parameter int MAX_BURST       = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ap_start,
  input  logic [OUT_BITS_TRANS-1:0] num_trans,
  input  logic [AXI_WIDTH_AD-1:0]   mem_start_addr,
  output logic                      ap_busy,
  output logic                      ap_done,
  output logic                      err_o,
  input  logic [AXI_WIDTH_DA-1:0]   s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [AXI_WIDTH_AD-1:0]   M_AWADDR,
  output logic [AXI_WIDTH_ID-1:0]   M_AWID,
  output logic [7:0]                M_AWLEN,
  output logic [2:0]                M_AWSIZE,
  output logic [1:0]                M_AWBURST,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  output logic [AXI_WIDTH_DA-1:0]   M_WDATA,
  output logic [AXI_WIDTH_DA/8-1:0] M_WSTRB,
  output logic                      M_WLAST,
  input  logic                      M_BVALID,
  output logic                      M_BREADY,
  input  logic [1:0]                M_BRESP,
  input  logic [AXI_WIDTH_ID-1:0]   M_BID
);

  localparam int BYTES = AXI_WIDTH_DA / 8;
  localparam int SZ    = bytes_log2(BYTES);
  localparam int CW    = OUT_BITS_TRANS + 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;

  state_t                  r_state;
  state_t                  w_next;
  logic [AXI_WIDTH_AD-1:0] r_addr;
  logic [CW-1:0]           r_remain;
  logic [OW-1:0]           r_outstanding;
  logic                    r_awvalid;
  logic [7:0]              r_awlen;
  logic [7:0]              r_wcnt;
  logic                    r_err;

  logic                    w_run;
  logic                    w_start;
  logic [12:0]             w_to_4k;
  logic [CW-1:0]           w_len;
  logic [8:0]              w_beats;
  logic                    w_aw_issue;
  logic                    w_aw_hs;
  logic                    w_w_active;
  logic                    w_w_hs;
  logic                    w_wlast;
  logic                    w_b_hs;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [7:0]              w_head;
  logic                    w_unused;

  assign w_unused = ^M_BID;

  // FSM: state register / next state / outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (ap_start) w_next = ST_RUN;
      ST_RUN:  if ((r_remain == '0) && w_fifo_empty && (r_outstanding == '0) && !r_awvalid)
                 w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ap_busy  = 1'b0;
    ap_done  = 1'b0;
    M_BREADY = 1'b0;
    w_run    = 1'b0;
    case (r_state)
      ST_RUN:  begin ap_busy = 1'b1; M_BREADY = 1'b1; w_run = 1'b1; end
      ST_DONE: begin ap_busy = 1'b1; ap_done = 1'b1; end
      default: ;
    endcase
  end

  assign w_start = (r_state == ST_IDLE) && ap_start;

  // Burst length: limited by remaining beats, MAX_BURST and the next 4 KB page
  assign w_to_4k = (13'(BOUNDARY_4K) - {1'b0, r_addr[11:0]}) >> SZ;

  always_comb begin
    w_len = r_remain;
    if (w_len > CW'(MAX_BURST)) w_len = CW'(MAX_BURST);
    if (w_len > CW'(w_to_4k))   w_len = CW'(w_to_4k);
  end

  assign w_aw_issue = w_run && !r_awvalid && (r_remain != '0) &&
                      (r_outstanding < OW'(MAX_OUTSTANDING)) && !w_fifo_full;
  assign w_aw_hs    = r_awvalid && M_AWREADY;
  assign w_beats    = {1'b0, r_awlen} + 9'd1;
  assign w_b_hs     = M_BVALID && M_BREADY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr        <= '0;
      r_remain      <= '0;
      r_outstanding <= '0;
      r_awvalid     <= 1'b0;
      r_awlen       <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr   <= mem_start_addr & ~AXI_WIDTH_AD'(BYTES - 1);
        r_remain <= {1'b0, num_trans};
        r_err    <= 1'b0;
      end else if (w_b_hs && (M_BRESP != RESP_OKAY)) begin
        r_err <= 1'b1;
      end
      if (w_aw_issue) begin
        r_awvalid <= 1'b1;
        r_awlen   <= 8'(w_len - CW'(1));
      end else if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_addr    <= r_addr + (AXI_WIDTH_AD'(w_beats) << SZ);
        r_remain  <= r_remain - CW'(w_beats);
      end
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  axi_dma_wr_len_fifo #(
    .WIDTH (8),
    .DEPTH (MAX_OUTSTANDING)
  ) u_len_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_aw_hs),
    .i_din   (r_awlen),
    .i_pop   (w_w_hs && w_wlast),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // The FIFO head is the length of the burst being streamed; it pops on WLAST
  assign w_w_active = !w_fifo_empty;
  assign w_wlast    = w_w_active && (r_wcnt == w_head);
  assign w_w_hs     = M_WVALID && M_WREADY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if (w_w_hs) begin
      r_wcnt <= w_wlast ? 8'd0 : r_wcnt + 8'd1;
    end
  end

  assign M_WVALID  = s_valid && w_w_active;
  assign s_ready   = M_WREADY && w_w_active;
  assign M_WDATA   = w_w_active ? s_data : '0;
  assign M_WLAST   = w_wlast;
  assign M_WSTRB   = '1;
  assign M_AWVALID = r_awvalid;
  assign M_AWADDR  = r_addr;
  assign M_AWLEN   = r_awlen;
  assign M_AWID    = '0;
  assign M_AWSIZE  = 3'(SZ);
  assign M_AWBURST = BURST_INCR;
  assign err_o     = r_err;

endmodule

// File: doc/axi_dma_wr_mo.md
Name: axi_dma_wr_mo

Overview:
- Next-generation AXI4 write DMA for the output path. Streams output feature-map words from the output buffer into DRAM.
- Parametrised data width and burst length.
- Splits bursts at 4 KB boundaries.
- Decouples AW, W and B channels so up to MAX_OUTSTANDING bursts are in flight.
- Reports write-response errors instead of silently retrying.

Parameters:
AXI_WIDTH_AD, 32, AXI address width
AXI_WIDTH_DA, 32, AXI data width (32/64/128)
AXI_WIDTH_ID, 4, AXI ID width
OUT_BITS_TRANS, 18, width of the transfer beat count
MAX_BURST, 256, max beats per burst (power of 2, 2..256)
MAX_OUTSTANDING, 4, max bursts issued on AW but not yet answered on B (power of 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ap_start  in  1  start pulse, sampled only in IDLE
num_trans  in  OUT_BITS_TRANS  total beats to write
mem_start_addr  in  AXI_WIDTH_AD  byte start address; low log2(DA/8) bits ignored
ap_busy  out  1  transfer in progress
ap_done  out  1  one-cycle completion pulse
err_o  out  1  sticky: a BRESP other than OKAY was seen in this transfer
s_data  in  AXI_WIDTH_DA  stream data from the output buffer
s_valid  in  1  stream data valid
s_ready  out  1  stream data accepted
M_AWVALID/M_AWREADY  out/in  1  AW handshake
M_AWADDR  out  AXI_WIDTH_AD  burst address
M_AWID  out  AXI_WIDTH_ID  constant 0
M_AWLEN  out  8  beats-1
M_AWSIZE  out  3  log2(DA/8)
M_AWBURST  out  2  constant INCR (2'b01)
M_WVALID/M_WREADY  out/in  1  W handshake
M_WDATA  out  AXI_WIDTH_DA  write data
M_WSTRB  out  DA/8  all ones
M_WLAST  out  1  last beat of burst
M_BVALID/M_BREADY  in/out  1  B handshake
M_BRESP  in  2  write response
M_BID  in  AXI_WIDTH_ID  ignored

Behaviour:
- Reset: every output is 0 except constant ties. FSM returns to IDLE, counters clear, length FIFO is flushed. Reset mid-burst abandons the transfer with no completion.
- Top FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on ap_start. num_trans and the aligned address are latched, err_o is cleared.
- num_trans==0: RUN exits straight to DONE.
- ap_start is ignored outside IDLE.
- DONE: ap_done=1 for exactly one cycle, then IDLE.
- ap_busy=1 in RUN and DONE.
- AW generator: burst length len = min(remaining beats, MAX_BURST, beats up to the next 4 KB boundary).
- AW issue condition: remaining>0, outstanding<MAX_OUTSTANDING, length FIFO not full.
- Once AWVALID is asserted, AWADDR and AWLEN hold stable until AWREADY.
- On AW handshake: address += len*DA/8, remaining -= len, len-1 is pushed to the length FIFO (depth MAX_OUTSTANDING), outstanding++.
- W engine: pops the FIFO when idle and non-empty, then streams that many beats.
- W is combinationally coupled in the W engine: M_WVALID=s_valid&w_active, s_ready=M_WREADY&w_active, M_WDATA=s_data. No W beat precedes its AW handshake.
- M_WLAST is high when beat counter == popped len. The next FIFO entry may pop in the cycle after WLAST handshake.
- B channel: M_BREADY=1 in RUN.
- On B handshake: outstanding--. If BRESP!=OKAY, err_o=1 and stays set until the next ap_start.
- Same-cycle AW and B handshakes leave outstanding unchanged.
- RUN -> DONE when remaining==0, FIFO empty, W engine idle, outstanding==0.
- Address arithmetic wraps modulo 2^AXI_WIDTH_AD.
- Beat count arithmetic uses OUT_BITS_TRANS+1 bits internally.
- Max AW->first-W latency: 1 cycle after the FIFO push.

Decomposition:
- Shared package axi_dma_pkg: SIZE_* encodings, RESP_* codes, BURST_INCR, the 4 KB boundary constant, and a log2 helper for DA/8.
- Sub-module axi_dma_wr_len_fifo: synchronous FIFO with width 8, depth MAX_OUTSTANDING, full/empty flags, async active-high reset.

Test Plan:
- DA=32, MAX_BURST=256, addr 0x1000_0000, num_trans=16, always-ready slave -> one AW (AWLEN=15, AWSIZE=2), 16 W beats with WLAST on the 16th, single ap_done pulse, err_o=0.
- num_trans=300 at 0x0 -> AWs at 0x000 (LEN=255) and 0x400 (LEN=43); 300 data words land in order.
- addr 0x0FF0, num_trans=20, DA=32 -> AW 0x0FF0 LEN=3, then AW 0x1000 LEN=15; no burst crosses the 4 KB line.
- MAX_OUTSTANDING=4, AWREADY=1, BVALID withheld -> exactly 4 AWs issued, AWVALID low until the first B; no deadlock once B is released.
- Random s_valid/M_WREADY backpressure on a 64-beat transfer with DA=64 -> data order preserved; AWADDR steps by 8 bytes per beat.
- Second burst answered with SLVERR -> err_o rises and stays high, ap_done still pulses. Also: num_trans=0 -> ap_done two cycles after ap_start with no AXI activity. Also: rst asserted mid-W -> all outputs 0 immediately.
